mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative multiply/divide unit for the MIPS datapath, sitting directly downstream of the register file. It consumes the two read-port values (rs → src_a, rt → src_b) and executes MULT, MULTU, DIV and DIVU over 34 cycles. Results land in architectural HI/LO registers, which MFHI/MFLO read and MTHI/MTLO write. The controller stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32, operand / HI / LO width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  launch operation (accepted only in IDLE or DONE)
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`
- `src_a`  in  WIDTH  multiplicand / dividend; sampled with `start`
- `src_b`  in  WIDTH  multiplier / divisor; sampled with `start`
- `hi_we`  in  1  MTHI write strobe
- `lo_we`  in  1  MTLO write strobe
- `wdata`  in  WIDTH  MTHI/MTLO data
- `busy`  out  1  high in RUN and ADJUST
- `done`  out  1  one-cycle pulse; HI/LO hold the new result
- `hi`  out  WIDTH  HI register (product upper half / remainder)
- `lo`  out  WIDTH  LO register (product lower half / quotient)

## Operation
- Reset (`rst`=0, asynchronous): state IDLE, `hi`=`lo`=0, `busy`=`done`=0, counter and internal accumulators 0.
- States and transitions:
  - IDLE → RUN on `start`.
  - RUN: 32 cycles, counter 0..31; RUN → ADJUST when counter = 31.
  - ADJUST → DONE: HI/LO written on this edge.
  - DONE → RUN on `start`; otherwise DONE → IDLE.
- Operands and op are latched on the accepting edge. Later changes to `src_a`/`src_b`/`op` have no effect.
- Signed ops compute on magnitudes and record the sign. In ADJUST:
  - product is negated (64-bit two's complement) if the operand signs differ;
  - quotient is negated if the signs differ;
  - remainder takes the dividend's sign.
- Multiply: shift-add, one multiplier bit per RUN cycle, into a 2·WIDTH accumulator. Result is `hi`=product[63:32], `lo`=product[31:0].
- Divide: restoring, one quotient bit per RUN cycle. Result is `lo`=quotient, `hi`=remainder.
- Divide by zero (DIV or DIVU): `lo`=0xFFFFFFFF, `hi`=src_a, no sign fix-up. Timing is unchanged (done still on cycle 34).
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0. This is the natural 32-bit wrap; no trap.
- MTHI/MTLO:
  - `hi_we`/`lo_we` write `wdata` on the next edge in IDLE or DONE only.
  - Ignored in RUN/ADJUST; the controller does not issue them while `busy`.
  - If a write coincides with an accepted `start`, the write happens, and the operation later overwrites HI/LO.
- `start` in RUN/ADJUST is ignored; no queueing.

## Timing
- `start` high at edge E0 → `busy`=1 in cycles 1..33 → `done`=1 and new HI/LO visible in cycle 34 → `busy`=0 in cycle 34.
- Latency is fixed at 34 cycles for all ops and all operand values.
- Back-to-back: `start` in the DONE cycle re-enters RUN with no idle gap, giving a 34-cycle issue interval.
- `hi`/`lo` are register outputs and change only on a write edge (ADJUST→DONE, MTHI/MTLO) or on reset.
- Reset asserted mid-operation: outputs go to their reset values immediately, without waiting for a clock; the partial result is discarded.

## Structure
- Shared package `mips_pkg`:
  - `md_op_t` enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - `md_state_t` enum (IDLE, RUN, ADJUST, DONE);
  - `MD_ITER` = 32.
- Single module. The multiply and divide datapaths share the counter and accumulator registers, so no sub-module is warranted.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `done` at cycle 34, `hi`=0xFFFFFFFE, `lo`=0x00000001; `busy` high exactly cycles 1..33.
- MULT −3 × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7 / 2 → `lo`=3, `hi`=1.
- DIV 0x1234 / 0 → `lo`=0xFFFFFFFF, `hi`=0x00001234. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MTHI 0xA5A5A5A5 in IDLE → `hi`=0xA5A5A5A5 next cycle. `hi_we` and a second `start` during RUN → both ignored, and the first result is correct.
- Reset pulse at RUN counter = 10 → `hi`=`lo`=0 and `busy`=0 before the next edge. After release, MULTU 2 × 3 → `lo`=6 at cycle 34.
- `start` in the DONE cycle with DIVU 100 / 7 → second `done` exactly 34 cycles after the first, with `lo`=14, `hi`=2.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions.
//   md_op_t    : multiply/divide operation encoding (matches the 2-bit op field)
//   md_state_t : multiply/divide sequencer states
//   MD_ITER    : number of iterative RUN cycles (one operand bit per cycle)
package mips_pkg;

   localparam int unsigned MD_ITER = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      ADJUST = 2'b10,
      DONE   = 2'b11
   } md_state_t;

   // Signed variants work on magnitudes and fix the sign up afterwards.
   function automatic logic isSignedOp(md_op_t o);
      return (o == MD_MULT) || (o == MD_DIV);
   endfunction

   function automatic logic isDivOp(md_op_t o);
      return (o == MD_DIV) || (o == MD_DIVU);
   endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; both take
// 32 RUN cycles plus one ADJUST cycle, so done pulses 34 cycles after start.
// Ports:
//   clk, rst (async, active-low)
//   start, op, src_a, src_b : launch an operation (accepted in IDLE/DONE)
//   hi_we, lo_we, wdata     : MTHI/MTLO writes (honoured in IDLE/DONE)
//   busy                    : high in RUN and ADJUST
//   done                    : one-cycle pulse when HI/LO hold a new result
//   hi, lo                  : HI/LO registers
module mul_div_unit
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(MD_ITER);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MD_ITER - 1);

   md_state_t          state;
   logic [CNT_W-1:0]   count;
   logic [2*WIDTH-1:0] acc;      // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
   logic [WIDTH-1:0]   bMag;     // multiplicand / divisor magnitude
   logic [WIDTH-1:0]   aRaw;     // original dividend, returned as HI on divide by zero
   logic               aNeg;
   logic               bNeg;
   logic               isDiv;
   logic               divZero;

   // Operand decode at the accepting edge.
   logic             signedIn;
   logic             aNegIn;
   logic             bNegIn;
   logic [WIDTH-1:0] aMagIn;
   logic [WIDTH-1:0] bMagIn;

   always_comb begin
      signedIn = isSignedOp(md_op_t'(op));
      aNegIn   = signedIn & src_a[WIDTH-1];
      bNegIn   = signedIn & src_b[WIDTH-1];
      aMagIn   = aNegIn ? -src_a : src_a;
      bMagIn   = bNegIn ? -src_b : src_b;
   end

   // One shift-add step: add multiplicand if the current multiplier bit is set, then shift right.
   logic [WIDTH:0]     mulSum;
   logic [2*WIDTH-1:0] mulNext;

   always_comb begin
      mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bMag} : '0);
      mulNext = {mulSum, acc[WIDTH-1:1]};
   end

   // One restoring-division step: shift in the next dividend bit and trial-subtract.
   logic [WIDTH:0]     divShift;
   logic [WIDTH+1:0]   divDiff;
   logic               divOk;
   logic [WIDTH-1:0]   divRem;
   logic [2*WIDTH-1:0] divNext;

   always_comb begin
      divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      divDiff  = {1'b0, divShift} - {2'b00, bMag};
      divOk    = ~divDiff[WIDTH+1];
      // Either branch is below the divisor, so WIDTH bits always suffice.
      divRem   = divOk ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
      divNext  = {divRem, acc[WIDTH-2:0], divOk};
   end

   // Sign fix-up applied in ADJUST.
   logic [WIDTH-1:0] resHi;
   logic [WIDTH-1:0] resLo;

   always_comb begin
      resHi = acc[2*WIDTH-1:WIDTH];
      resLo = acc[WIDTH-1:0];
      if (!isDiv) begin
         if (aNeg ^ bNeg) begin
            {resHi, resLo} = -acc;
         end
      end else if (divZero) begin
         resHi = aRaw;
         resLo = '1;
      end else begin
         if (aNeg ^ bNeg) begin
            resLo = -acc[WIDTH-1:0];
         end
         if (aNeg) begin
            resHi = -acc[2*WIDTH-1:WIDTH];
         end
      end
   end

   // Sequencer, datapath registers and HI/LO.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         count   <= '0;
         acc     <= '0;
         bMag    <= '0;
         aRaw    <= '0;
         aNeg    <= 1'b0;
         bNeg    <= 1'b0;
         isDiv   <= 1'b0;
         divZero <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (hi_we) begin
                  hi <= wdata;
               end
               if (lo_we) begin
                  lo <= wdata;
               end
               if (start) begin
                  acc     <= {{WIDTH{1'b0}}, aMagIn};
                  bMag    <= bMagIn;
                  aRaw    <= src_a;
                  aNeg    <= aNegIn;
                  bNeg    <= bNegIn;
                  isDiv   <= isDivOp(md_op_t'(op));
                  divZero <= (src_b == '0);
                  count   <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               acc   <= isDiv ? divNext : mulNext;
               count <= count + CNT_W'(1);
               if (count == LAST_CNT) begin
                  state <= ADJUST;
               end
            end
            ADJUST: begin
               hi    <= resHi;
               lo    <= resLo;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: the driver pushes the expected HI/LO and
// done edge for each accepted operation; a monitor pops and compares on done.
module tb_mul_div_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      longint      doneEdge;
   } exp_t;

   exp_t        q[$];
   longint      edges = 0;
   int unsigned nCompared = 0;
   int unsigned nMismatched = 0;
   logic [31:0] curHi = 0;
   logic [31:0] curLo = 0;

   always @(posedge clk) edges <= edges + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      nCompared++;
      if (act !== expv) begin
         nMismatched++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, expv, $time);
      end
   endtask

   // Reference model from the arithmetic definitions; returns {hi, lo}.
   function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint p;
      longint qq;
      longint rr;
      logic [63:0] ua;
      logic [63:0] ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (o)
         2'b00: begin
            p = sa * sb;
            return 64'(p);
         end
         2'b01: return ua * ub;
         2'b10: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            qq = sa / sb;
            rr = sa % sb;
            return {32'(rr), 32'(qq)};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst && done) begin
         if (q.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("FAIL spurious_done: got done=1 expected no pending op at t=%0t", $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("result_hi", 64'(hi), 64'(e.hi));
            chk("result_lo", 64'(lo), 64'(e.lo));
            chk("done_edge", 64'(edges), 64'(e.doneEdge));
            curHi = e.hi;
            curLo = e.lo;
         end
      end
   end

   // Called at a negedge; returns at the negedge of cycle 1 of the operation.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [63:0] r;
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      @(negedge clk);
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      op    = 2'($urandom);
      src_a = $urandom;
      src_b = $urandom;
      r = refModel(o, a, b);
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.doneEdge = edges + 33;
      q.push_back(e);
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         nCompared++;
         nMismatched++;
         $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
      end
   endtask

   initial begin
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      int          sel;

      rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_hi", 64'(hi), 64'(0));
      chk("reset_lo", 64'(lo), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_done", 64'(done), 64'(0));
      rst = 1'b1;
      @(negedge clk);

      // MTHI / MTLO in IDLE
      hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
      @(negedge clk);
      hi_we = 1'b0;
      curHi = 32'hA5A5_A5A5;
      chk("mthi_idle", 64'(hi), 64'(curHi));
      lo_we = 1'b1; wdata = 32'h5A5A_1234;
      @(negedge clk);
      lo_we = 1'b0;
      curLo = 32'h5A5A_1234;
      chk("mtlo_idle", 64'(lo), 64'(curLo));
      chk("mtlo_keeps_hi", 64'(hi), 64'(curHi));

      // MULTU max x max with cycle-exact busy/done profile
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int k = 1; k <= 34; k++) begin
         chk($sformatf("busy_cyc%0d", k), 64'(busy), 64'(k <= 33));
         chk($sformatf("done_cyc%0d", k), 64'(done), 64'(k == 34));
         if (k < 34) begin
            chk($sformatf("hi_hold_cyc%0d", k), 64'(hi), 64'(curHi));
            @(negedge clk);
         end
      end
      @(negedge clk);
      chk("done_one_pulse", 64'(done), 64'(0));

      // Directed ops, issued back-to-back from the DONE cycle
      issue(2'b00, 32'hFFFF_FFFD, 32'd7);        waitDone();
      issue(2'b10, 32'hFFFF_FFF9, 32'd2);        waitDone();
      issue(2'b11, 32'd7, 32'd2);                waitDone();
      issue(2'b10, 32'h0000_1234, 32'd0);        waitDone();
      issue(2'b11, 32'hDEAD_BEEF, 32'd0);        waitDone();
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); waitDone();
      issue(2'b00, 32'h8000_0000, 32'h8000_0000); waitDone();
      issue(2'b11, 32'd100, 32'd7);              waitDone();
      @(negedge clk);

      // MTHI and a second start during RUN are ignored
      issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (4) @(negedge clk);
      hi_we = 1'b1; wdata = 32'hCAFE_F00D; start = 1'b1;
      op = 2'b10; src_a = 32'd99; src_b = 32'd5;
      @(negedge clk);
      hi_we = 1'b0; start = 1'b0;
      chk("mthi_in_run_ignored", 64'(hi), 64'(curHi));
      chk("busy_in_run", 64'(busy), 64'(1));
      waitDone();
      @(negedge clk);

      // MTLO coinciding with an accepted start: write lands, result overwrites later
      lo_we = 1'b1; wdata = 32'hC3C3_C3C3;
      issue(2'b10, 32'd1000, 32'hFFFF_FFFD);
      curLo = 32'hC3C3_C3C3;
      chk("mtlo_with_start", 64'(lo), 64'(curLo));
      waitDone();
      @(negedge clk);

      // Asynchronous reset in the middle of RUN (counter = 10)
      issue(2'b01, 32'hDEAD_0001, 32'hBEEF_0003);
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrun_reset_hi", 64'(hi), 64'(0));
      chk("midrun_reset_lo", 64'(lo), 64'(0));
      chk("midrun_reset_busy", 64'(busy), 64'(0));
      q.delete();
      curHi = '0;
      curLo = '0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      issue(2'b01, 32'd2, 32'd3);
      waitDone();

      // Randomised ops with random gaps and edge-case operands
      for (int i = 0; i < 40; i++) begin
         o   = 2'($urandom);
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) b = 32'd0;
         if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         if (sel == 2) b = 32'($urandom_range(1, 15));
         if (sel == 3) a = 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         issue(o, a, b);
         waitDone();
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(q.size()), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
